// File: rtl/me_pkg.sv
// Shared matching-engine types, widths and small helpers used by the
// trade history buffer and its RAM.
package me_pkg;

  localparam int PRICE_W    = 8;
  localparam int CNT_W      = 16;
  localparam int HIST_DEPTH = 64;

  localparam logic [PRICE_W-1:0] PRICE_MIN = 8'h00;
  localparam logic [PRICE_W-1:0] PRICE_MAX = 8'hFF;

  typedef logic [PRICE_W-1:0] price_t;
  typedef logic [CNT_W-1:0]   cnt_t;

  // Saturating increment: a counter pinned at all-ones stays there.
  function automatic cnt_t sat_inc(input cnt_t v);
    return (v == {CNT_W{1'b1}}) ? v : v + cnt_t'(1);
  endfunction

  // Ask minus bid in 9 bits; a crossed or locked book reports zero.
  function automatic price_t calc_spread(input price_t bid, input price_t ask);
    logic [PRICE_W:0] diff;
    diff = {1'b0, ask} - {1'b0, bid};
    return (ask > bid) ? diff[PRICE_W-1:0] : '0;
  endfunction

endpackage

// File: rtl/trade_history_buffer_if.sv
// Bundle of matching-engine inputs, the VGA read port and the statistics
// outputs of the trade history buffer.
interface trade_history_buffer_if
  import me_pkg::*;
#(
  parameter int DEPTH = HIST_DEPTH
);
  localparam int AW = $clog2(DEPTH);

  logic          match_signal;
  price_t        trade_price;
  price_t        best_bid;
  price_t        best_ask;
  logic          freeze;
  logic [AW-1:0] rd_addr;
  price_t        rd_data;
  logic          rd_hit;
  logic [AW:0]   count;
  cnt_t          trade_count;
  cnt_t          drop_count;
  price_t        last_price;
  price_t        min_price;
  price_t        max_price;
  price_t        spread;

  // Upstream side: engine feed plus the scan logic issuing reads.
  modport master (
    output match_signal, trade_price, best_bid, best_ask, freeze, rd_addr,
    input  rd_data, rd_hit, count, trade_count, drop_count,
           last_price, min_price, max_price, spread
  );

  // The history buffer itself.
  modport slave (
    input  match_signal, trade_price, best_bid, best_ask, freeze, rd_addr,
    output rd_data, rd_hit, count, trade_count, drop_count,
           last_price, min_price, max_price, spread
  );

endinterface

// File: rtl/trade_ring_ram.sv
// Simple dual-port history RAM: one write port, one registered read port.
// A read of the address being written on the same edge returns the old data.
module trade_ring_ram #(
  parameter  int DEPTH = 64,
  parameter  int WIDTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // Write and registered read share one block so the read sees pre-write data.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/trade_history_buffer.sv
// Captures matched trades into a circular history and keeps running trade
// statistics; exposes an age-indexed read port (0 = newest) for the VGA side.
module trade_history_buffer
  import me_pkg::*;
#(
  parameter  int DEPTH = HIST_DEPTH,
  localparam int AW    = $clog2(DEPTH)
) (
  input logic                  clk,
  input logic                  reset,
  trade_history_buffer_if.slave bus
);

  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

  // Trade price delayed one cycle: the registered match flag refers to the
  // price that was on the bus one cycle earlier.
  price_t        price_dly_q, price_dly_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0]   count_q, count_d;
  cnt_t          trade_cnt_q, trade_cnt_d;
  cnt_t          drop_cnt_q, drop_cnt_d;
  price_t        last_q, last_d;
  price_t        min_q, min_d;
  price_t        max_q, max_d;
  logic          have_q, have_d;
  price_t        spread_q, spread_d;
  logic          rd_hit_q, rd_hit_d;

  logic          trade_evt;
  logic          drop_evt;
  logic [AW-1:0] rd_phys;
  price_t        ram_rdata;

  assign trade_evt = bus.match_signal & ~bus.freeze;
  assign drop_evt  = bus.match_signal &  bus.freeze;

  // Age index to physical slot, relative to the pointer before this edge.
  assign rd_phys = wr_ptr_q - AW'(1) - bus.rd_addr;

  trade_ring_ram #(
    .DEPTH (DEPTH),
    .WIDTH (PRICE_W)
  ) u_ram (
    .clk   (clk),
    .we    (trade_evt),
    .waddr (wr_ptr_q),
    .wdata (price_dly_q),
    .raddr (rd_phys),
    .rdata (ram_rdata)
  );

  // Next-state for pointer, counters and statistics.
  always_comb begin
    price_dly_d = bus.trade_price;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    trade_cnt_d = trade_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    last_d      = last_q;
    min_d       = min_q;
    max_d       = max_q;
    have_d      = have_q;
    spread_d    = calc_spread(bus.best_bid, bus.best_ask);
    rd_hit_d    = ({1'b0, bus.rd_addr} < count_q);

    if (trade_evt) begin
      wr_ptr_d    = wr_ptr_q + AW'(1);
      count_d     = (count_q == DEPTH_CNT) ? count_q : count_q + (AW+1)'(1);
      trade_cnt_d = sat_inc(trade_cnt_q);
      last_d      = price_dly_q;
      // The first trade seeds both extremes, so 0x00/0xFF prices still land.
      if (!have_q || (price_dly_q < min_q)) min_d = price_dly_q;
      if (!have_q || (price_dly_q > max_q)) max_d = price_dly_q;
      have_d      = 1'b1;
    end

    if (drop_evt) begin
      drop_cnt_d = sat_inc(drop_cnt_q);
    end
  end

  // State registers, cleared immediately by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      price_dly_q <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      trade_cnt_q <= '0;
      drop_cnt_q  <= '0;
      last_q      <= '0;
      min_q       <= PRICE_MAX;
      max_q       <= PRICE_MIN;
      have_q      <= 1'b0;
      spread_q    <= '0;
      rd_hit_q    <= 1'b0;
    end else begin
      price_dly_q <= price_dly_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      trade_cnt_q <= trade_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
      last_q      <= last_d;
      min_q       <= min_d;
      max_q       <= max_d;
      have_q      <= have_d;
      spread_q    <= spread_d;
      rd_hit_q    <= rd_hit_d;
    end
  end

  // RAM contents survive reset; the registered hit flag masks stale data.
  assign bus.rd_data     = rd_hit_q ? ram_rdata : '0;
  assign bus.rd_hit      = rd_hit_q;
  assign bus.count       = count_q;
  assign bus.trade_count = trade_cnt_q;
  assign bus.drop_count  = drop_cnt_q;
  assign bus.last_price  = last_q;
  assign bus.min_price   = min_q;
  assign bus.max_price   = max_q;
  assign bus.spread      = spread_q;

endmodule

// File: tb/tb_trade_history_buffer.sv
// Randomised and directed check of trade_history_buffer against a queue-based
// model of the trade history and its statistics.
module tb_trade_history_buffer;
  import me_pkg::*;

  localparam int DEPTH = 4;
  localparam int AW    = $clog2(DEPTH);

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  trade_history_buffer_if #(.DEPTH(DEPTH)) bus();

  trade_history_buffer #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Reference model: newest trade at the front of the queue.
  int    hist[$];
  int    m_trades, m_drops, m_last, m_min, m_max, m_spread, m_prev;
  bit    m_have;
  int    exp_rd_data;
  bit    exp_rd_hit;

  int    n_cmp = 0;
  int    n_err = 0;
  string phase = "init";

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s/%s got=0x%0h expected=0x%0h @%0t", phase, tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    m_trades = 0; m_drops = 0; m_last = 0;
    m_min = 255; m_max = 0; m_have = 0;
    m_spread = 0; m_prev = 0;
    exp_rd_data = 0; exp_rd_hit = 0;
  endtask

  task automatic check_all();
    chk("rd_data",     32'(bus.rd_data),     exp_rd_data);
    chk("rd_hit",      32'(bus.rd_hit),      32'(exp_rd_hit));
    chk("count",       32'(bus.count),       hist.size());
    chk("trade_count", 32'(bus.trade_count), m_trades);
    chk("drop_count",  32'(bus.drop_count),  m_drops);
    chk("last_price",  32'(bus.last_price),  m_last);
    chk("min_price",   32'(bus.min_price),   m_min);
    chk("max_price",   32'(bus.max_price),   m_max);
    chk("spread",      32'(bus.spread),      m_spread);
  endtask

  task automatic drive(input bit m, input bit f, input int tp, input int bid,
                       input int ask, input int ra);
    bus.match_signal = m;
    bus.freeze       = f;
    bus.trade_price  = 8'(tp);
    bus.best_bid     = 8'(bid);
    bus.best_ask     = 8'(ask);
    bus.rd_addr      = AW'(ra);
  endtask

  // One clock: capture pre-edge inputs, advance the model, then check.
  task automatic cycle();
    bit m, f;
    int tp, bid, ask, ra;
    m   = bus.match_signal;
    f   = bus.freeze;
    tp  = int'(bus.trade_price);
    bid = int'(bus.best_bid);
    ask = int'(bus.best_ask);
    ra  = int'(bus.rd_addr);
    @(posedge clk);
    if (reset) begin
      model_reset();
    end else begin
      exp_rd_hit  = (ra < hist.size());
      exp_rd_data = exp_rd_hit ? hist[ra] : 0;
      if (m && !f) begin
        hist.push_front(m_prev);
        if (hist.size() > DEPTH) void'(hist.pop_back());
        if (m_trades < 65535) m_trades++;
        m_last = m_prev;
        if (!m_have || m_prev < m_min) m_min = m_prev;
        if (!m_have || m_prev > m_max) m_max = m_prev;
        m_have = 1;
      end else if (m && f) begin
        if (m_drops < 65535) m_drops++;
      end
      m_spread = (ask > bid) ? ask - bid : 0;
      m_prev   = tp;
    end
    #1;
    check_all();
  endtask

  // Asynchronous reset pulse between clock edges; effect must be immediate.
  task automatic pulse_reset();
    reset = 1'b1;
    #1;
    model_reset();
    chk("rst_async_count", 32'(bus.count), 0);
    chk("rst_async_trades", 32'(bus.trade_count), 0);
    chk("rst_async_min", 32'(bus.min_price), 32'h0000_00FF);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    model_reset();
    reset = 1'b1;
    drive($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 255),
          $urandom_range(0, 255), $urandom_range(0, 255), 0);
    #1;

    // Reset with random inputs.
    phase = "reset";
    for (int i = 0; i < 3; i++) begin
      drive($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 255),
            $urandom_range(0, 255), $urandom_range(0, 255), 0);
      cycle();
    end
    chk("rst_min", 32'(bus.min_price), 32'h0000_00FF);
    chk("rst_max", 32'(bus.max_price), 0);
    chk("rst_hit", 32'(bus.rd_hit), 0);
    reset = 1'b0;

    // Trade uses the price registered one cycle before the match.
    phase = "align";
    drive(0, 0, 8'h40, 0, 0, 0); cycle();
    drive(1, 0, 8'h99, 0, 0, 0); cycle();
    chk("align_last", 32'(bus.last_price), 32'h40);
    drive(0, 0, 8'h00, 0, 0, 0); cycle();
    chk("align_rd", 32'(bus.rd_data), 32'h40);

    // Wrap: prices 1..6 into a 4-deep history.
    phase = "wrap";
    pulse_reset();
    drive(0, 0, 1, 0, 0, 0); cycle();
    for (int p = 2; p <= 7; p++) begin
      drive(1, 0, p, 0, 0, 0); cycle();
    end
    chk("wrap_count", 32'(bus.count), 4);
    chk("wrap_trades", 32'(bus.trade_count), 6);
    for (int a = 0; a < 4; a++) begin
      drive(0, 0, 0, 0, 0, a); cycle();
      chk("wrap_rd", 32'(bus.rd_data), 32'(6 - a));
    end

    // Freeze drops trades without touching the history.
    phase = "freeze";
    pulse_reset();
    drive(0, 0, 8'h11, 0, 0, 0); cycle();
    for (int i = 0; i < 3; i++) begin drive(1, 0, $urandom_range(0, 255), 0, 0, 0); cycle(); end
    for (int i = 0; i < 2; i++) begin drive(1, 1, $urandom_range(0, 255), 0, 0, 0); cycle(); end
    drive(1, 0, $urandom_range(0, 255), 0, 0, 0); cycle();
    chk("frz_trades", 32'(bus.trade_count), 4);
    chk("frz_drops", 32'(bus.drop_count), 2);
    chk("frz_count", 32'(bus.count), 4);

    // Min/max tracking and first-trade seeding.
    phase = "stats";
    pulse_reset();
    drive(0, 0, 8'h80, 0, 0, 0); cycle();
    drive(1, 0, 8'h10, 0, 0, 0); cycle();
    drive(1, 0, 8'hF0, 0, 0, 0); cycle();
    drive(1, 0, 8'h00, 0, 0, 0); cycle();
    chk("stat_min", 32'(bus.min_price), 32'h10);
    chk("stat_max", 32'(bus.max_price), 32'hF0);
    pulse_reset();
    drive(0, 0, 8'hFF, 0, 0, 0); cycle();
    drive(1, 0, 8'h00, 0, 0, 0); cycle();
    chk("stat_ff_min", 32'(bus.min_price), 32'hFF);
    chk("stat_ff_max", 32'(bus.max_price), 32'hFF);
    drive(0, 0, 0, 8'h60, 8'h50, 0); cycle();
    chk("spread_neg", 32'(bus.spread), 0);
    drive(0, 0, 0, 8'h50, 8'h60, 0); cycle();
    chk("spread_pos", 32'(bus.spread), 32'h10);

    // Read of the oldest slot on the same edge it is overwritten.
    phase = "collide";
    pulse_reset();
    drive(0, 0, 8'hA0, 0, 0, 0); cycle();
    for (int i = 1; i <= 4; i++) begin drive(1, 0, 8'hA0 + i, 0, 0, 0); cycle(); end
    drive(1, 0, 8'h55, 0, 0, DEPTH - 1); cycle();
    chk("collide_old", 32'(bus.rd_data), 32'hA0);
    drive(0, 0, 0, 0, 0, DEPTH - 1); cycle();
    chk("collide_next", 32'(bus.rd_data), 32'hA1);

    // Reset mid-stream empties the history.
    phase = "rst_mid";
    drive(1, 0, 8'h33, 0, 0, 0); cycle();
    pulse_reset();
    drive(0, 0, 0, 0, 0, 0); cycle();
    chk("rstmid_hit", 32'(bus.rd_hit), 0);
    chk("rstmid_count", 32'(bus.count), 0);

    // Randomised traffic with occasional resets.
    phase = "random";
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 1), ($urandom_range(0, 4) == 0),
            $urandom_range(0, 255), $urandom_range(0, 255),
            $urandom_range(0, 255), $urandom_range(0, DEPTH - 1));
      if ($urandom_range(0, 7) == 0) bus.best_ask = bus.best_bid;
      if ($urandom_range(0, 199) == 0) pulse_reset();
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
